// File: rtl/rvx_core_div.sv
// rvx_core_div: iterative radix-2^BITS_PER_CYCLE restoring divider for RV32M DIV/DIVU/REM/REMU.
// Build option: define RVX_DIV_EARLY_OUT_EN to send divide-by-zero and signed overflow straight to DONE.
module rvx_core_div #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        div_start_s2,
  input  logic        div_kill_s2,
  input  logic [2:0]  funct3_s2,
  input  logic [31:0] rs1_data_s2,
  input  logic [31:0] rs2_data_s2,
  output logic        div_busy_s2,
  output logic        div_done_s2,
  output logic [31:0] div_output_s2,
  output logic [1:0]  div_state_dbg
);

  localparam int         ITER = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] dvd_q;      // dividend bits still to shift in; fills with quotient bits
  logic [31:0] dvs_q;
  logic [32:0] rem_q;
  logic        is_rem_q, neg_q_q, neg_r_q;
  logic [31:0] out_q;

  logic        is_signed, accept;
  logic [31:0] abs1, abs2;
  logic [31:0] dvd_n;
  logic [32:0] rem_n;
  logic [33:0] diff;
  logic [31:0] quo_fix, rem_fix, result;

  // Handshake: start is taken only in IDLE with kill low; busy covers the op through its
  // done cycle; done pulses for one cycle with the result on div_output_s2.
  assign is_signed = funct3_s2[2] & ~funct3_s2[0];
  assign accept    = (state_q == S_IDLE) & div_start_s2 & ~div_kill_s2;
  assign abs1      = (is_signed & rs1_data_s2[31]) ? 32'd0 - rs1_data_s2 : rs1_data_s2;
  assign abs2      = (is_signed & rs2_data_s2[31]) ? 32'd0 - rs2_data_s2 : rs2_data_s2;

`ifdef RVX_DIV_EARLY_OUT_EN
  logic div_zero, signed_ovf, early_out;
  assign div_zero   = (rs2_data_s2 == 32'd0);
  assign signed_ovf = is_signed & (rs1_data_s2 == 32'h8000_0000) & (rs2_data_s2 == 32'hFFFF_FFFF);
  assign early_out  = div_zero | signed_ovf;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef RVX_DIV_EARLY_OUT_EN
          state_d = early_out ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC:  if (count_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (div_kill_s2) state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Restoring steps; the 34-bit difference exposes the borrow without truncating 2^31.
  always_comb begin
    rem_n = rem_q;
    dvd_n = dvd_q;
    diff  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      diff  = {rem_n, dvd_n[31]} - {2'b00, dvs_q};
      rem_n = diff[33] ? {rem_n[31:0], dvd_n[31]} : diff[32:0];
      dvd_n = {dvd_n[30:0], ~diff[33]};
    end
  end

  assign quo_fix = neg_q_q ? 32'd0 - dvd_q : dvd_q;
  assign rem_fix = neg_r_q ? 32'd0 - rem_q[31:0] : rem_q[31:0];
  assign result  = is_rem_q ? rem_fix : quo_fix;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      if (accept) begin
        is_rem_q <= funct3_s2[2] & funct3_s2[1];
        // A zero divisor keeps its all-ones quotient unsigned-looking.
        neg_q_q  <= is_signed & (rs1_data_s2[31] ^ rs2_data_s2[31]) & (rs2_data_s2 != 32'd0);
        neg_r_q  <= is_signed & rs1_data_s2[31];
        dvs_q    <= abs2;
        count_q  <= '0;
`ifdef RVX_DIV_EARLY_OUT_EN
        if (div_zero) begin
          dvd_q <= 32'hFFFF_FFFF;
          rem_q <= {1'b0, abs1};
        end else if (signed_ovf) begin
          dvd_q <= 32'h8000_0000;
          rem_q <= '0;
        end else begin
          dvd_q <= abs1;
          rem_q <= '0;
        end
`else
        dvd_q <= abs1;
        rem_q <= '0;
`endif
      end else if ((state_q == S_CALC) && !div_kill_s2) begin
        dvd_q   <= dvd_n;
        rem_q   <= rem_n;
        count_q <= count_q + 5'd1;
      end
      if ((state_q == S_DONE) && !div_kill_s2) out_q <= result;
    end
  end

  assign div_busy_s2   = (state_q != S_IDLE);
  assign div_done_s2   = (state_q == S_DONE) & ~div_kill_s2;
  assign div_output_s2 = div_done_s2 ? result : out_q;
  assign div_state_dbg = state_q;

endmodule
